// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding uart_tx one frame at a time: pops a byte, pulses send,
// then holds the byte stable until uart_tx reports done.
module uart_tx_queue #(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  input  logic              tx_done,
  output logic              busy
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                accept;
  logic                pop;
  logic [CW-1:0]       count_next;

  // full is the pre-edge view, so a same-cycle pop never frees room for a write
  always_comb begin
    accept = wr_en && !full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          next_state = SEND;
          pop        = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      SEND:    next_state = WAIT;
      WAIT:    next_state = tx_done ? IDLE : WAIT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (accept && !pop)      count_next = count + CW'(1);
    else if (!accept && pop) count_next = count - CW'(1);
  end

  // Storage is not reset; only the pointers and occupancy are
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_byte  <= 8'h00;
      tx_send  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_byte <= mem[rd_ptr];
      end
      count   <= count_next;
      full    <= (count_next == CW'(DEPTH));
      empty   <= (count_next == CW'(0));
      tx_send <= (next_state == SEND);
      busy    <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue; the bench plays the role of uart_tx by
// pulsing tx_done and logs every byte presented with tx_send.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       tx_done = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       busy;

  int total = 0;
  int bad = 0;
  logic [7:0] sent_q[$];

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_byte(tx_byte), .tx_send(tx_send), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Values seen at the edge that closes the SEND cycle
  always @(posedge clk) if (tx_send) sent_q.push_back(tx_byte);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as uart_tx: answers every frame with done until the queue is idle
  task automatic drain(input string name);
    int n = 0;
    while (!(empty && !busy) && n < 400) begin
      if (busy && !tx_send) begin
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    total++;
    if (!(empty && !busy)) begin
      bad++;
      $display("FAIL %s_drain: empty=%b busy=%b required empty=1 busy=0", name, empty, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (count !== 5'd0)     begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (tx_send !== 1'b0)   begin bad++; $display("FAIL reset_send: got %b want 0", tx_send); end
    total++; if (tx_byte !== 8'h00)  begin bad++; $display("FAIL reset_byte: got %h want 00", tx_byte); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    sent_q.delete();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    total++; if (empty !== 1'b0)   begin bad++; $display("FAIL single_empty: got %b want 0", empty); end
    total++; if (count !== 5'd1)   begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL single_early_send: got %b want 0", tx_send); end
    tick();
    total++; if (tx_send !== 1'b1)  begin bad++; $display("FAIL single_send: got %b want 1", tx_send); end
    total++; if (tx_byte !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", tx_byte); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    total++; if (tx_send !== 1'b0)  begin bad++; $display("FAIL single_send_width: got %b want 0", tx_send); end
    repeat (3) tick();
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL single_wait_busy: got %b want 1", busy); end
    total++; if (tx_byte !== 8'hA5) begin bad++; $display("FAIL single_wait_byte: got %h want a5", tx_byte); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL single_done_busy: got %b want 0", busy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_done_empty: got %b want 1", empty); end
    total++; if (sent_q.size() != 1) begin bad++; $display("FAIL single_sends: got %0d want 1", sent_q.size()); end
  endtask

  task automatic test_burst();
    logic [4:0] exp_cnt [5] = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4};
    sent_q.delete();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
      total++;
      if (count !== exp_cnt[i]) begin bad++; $display("FAIL burst_count%0d: got %0d want %0d", i, count, exp_cnt[i]); end
    end
    wr_en = 1'b0;
    drain("burst");
    total++; if (sent_q.size() != 5) begin bad++; $display("FAIL burst_sends: got %0d want 5", sent_q.size()); end
    for (int i = 0; i < 5 && i < sent_q.size(); i++) begin
      total++;
      if (sent_q[i] !== 8'(i + 1)) begin bad++; $display("FAIL burst_order%0d: got %h want %h", i, sent_q[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_full_overflow();
    sent_q.delete();
    wr_en = 1'b1; wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h10 + i);
      tick();
      total++;
      if (count !== 5'((i < 16) ? i + 1 : 16) || overflow !== (i == 16) || full !== (i >= 15)) begin
        bad++;
        $display("FAIL fill%0d: count=%0d ovf=%b full=%b want count=%0d ovf=%b full=%b",
                 i, count, overflow, full, (i < 16) ? i + 1 : 16, i == 16, i >= 15);
      end
    end
    wr_en = 1'b0;
    tick();
    total++; if (overflow !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL ovf_pulse: ovf=%b count=%0d want 0 16", overflow, count); end
    // Release the in-flight byte, then write on the popping edge while full
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++; if (busy !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL full_idle: busy=%b count=%0d want 0 16", busy, count); end
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pop_write_ovf: got %b want 1", overflow); end
    total++; if (count !== 5'd15)   begin bad++; $display("FAIL pop_write_count: got %0d want 15", count); end
    total++; if (tx_send !== 1'b1 || tx_byte !== 8'h10) begin bad++; $display("FAIL pop_write_send: send=%b byte=%h want 1 10", tx_send, tx_byte); end
    drain("full");
    total++; if (sent_q.size() != 17) begin bad++; $display("FAIL full_sends: got %0d want 17", sent_q.size()); end
    for (int i = 0; i < 17 && i < sent_q.size(); i++) begin
      total++;
      if (sent_q[i] !== ((i == 0) ? 8'hC3 : 8'(32'h0F + i))) begin
        bad++; $display("FAIL full_order%0d: got %h want %h", i, sent_q[i], (i == 0) ? 8'hC3 : 8'(32'h0F + i));
      end
    end
  endtask

  task automatic test_last_entry();
    wr_en = 1'b1; wr_data = 8'h31;
    tick();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL last_count_a: got %0d want 1", count); end
    wr_data = 8'h32;
    tick();
    wr_en = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL last_count_b: got %0d want 1", count); end
    total++; if (tx_send !== 1'b1 || tx_byte !== 8'h31) begin bad++; $display("FAIL last_send: send=%b byte=%h want 1 31", tx_send, tx_byte); end
    drain("last");
  endtask

  task automatic test_hold();
    sent_q.delete();
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    tick();
    // done during SEND must not disturb the sequence
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = (i < 2); wr_data = (i == 0) ? 8'h66 : 8'h77;
      tick();
      total++;
      if (tx_byte !== 8'h55 || tx_send !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL hold%0d: byte=%h send=%b busy=%b want 55 0 1", i, tx_byte, tx_send, busy);
      end
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd2) begin bad++; $display("FAIL hold_count: got %0d want 2", count); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++; if (busy !== 1'b0 || tx_send !== 1'b0) begin bad++; $display("FAIL hold_done: busy=%b send=%b want 0 0", busy, tx_send); end
    tick();
    total++; if (tx_send !== 1'b1 || tx_byte !== 8'h66) begin bad++; $display("FAIL hold_next: send=%b byte=%h want 1 66", tx_send, tx_byte); end
    drain("hold");
    total++; if (sent_q.size() != 3) begin bad++; $display("FAIL hold_sends: got %0d want 3", sent_q.size()); end
  endtask

  task automatic test_reset_midframe();
    sent_q.delete();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h41 + i);
      tick();
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd3 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre: count=%0d busy=%b want 3 1", count, busy); end
    rst_n = 1'b0;
    #1;
    total++; if (count !== 5'd0 || tx_send !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL mid_reset: count=%0d send=%b busy=%b empty=%b want 0 0 0 1", count, tx_send, busy, empty);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    tick();
    total++; if (tx_send !== 1'b1 || tx_byte !== 8'h5A) begin bad++; $display("FAIL mid_after: send=%b byte=%h want 1 5a", tx_send, tx_byte); end
    drain("mid");
    total++; if (sent_q.size() != 2) begin bad++; $display("FAIL mid_sends: got %0d want 2", sent_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_last_entry();
    test_hold();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
